multi_ch_pattern_out: RTL and testbench
=======================================

MULTI_CH_PATTERN_OUT -- requirements
Module: multi_ch_pattern_out

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 32, meaning pattern length per channel in bits (multiple of 8).
REQ-002 The block SHALL have parameter CH_NUM, default 16, meaning number of output channels (max 16).
REQ-003 The block SHALL have parameter PERIOD_BIT, default 8, meaning width of per-channel bit-period registers.
REQ-004 The block SHALL have parameter TIMEOUT_CLK, default 50000, meaning maximum clk cycles allowed between bytes of one packet.
REQ-005 The block SHALL have port clk, input, 1, meaning system clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-high.
REQ-007 The block SHALL have port i_data, input, 8, meaning received byte.
REQ-008 The block SHALL have port i_rx_done_tick, input, 1, meaning one-cycle strobe qualifying i_data.
REQ-009 The block SHALL have port o_serial_out, output, CH_NUM, meaning per-channel serial pattern.
REQ-010 The block SHALL have port o_bit_tick, output, CH_NUM, meaning one-cycle pulse on the last cycle of each bit.
REQ-011 The block SHALL have port o_done_tick, output, CH_NUM, meaning one-cycle pulse on the last cycle of a pattern pass.
REQ-012 The block SHALL have port o_busy, output, CH_NUM, meaning channel in RUN.
REQ-013 The block SHALL have port o_pkt_err, output, 1, meaning one-cycle pulse on a discarded packet.

Function
REQ-014 Packet length SHALL be PACK_NUM = 2*DATA_BIT/8 + 3 bytes, in order: output pattern, frequency pattern (each LSB byte first), low period, high period, control.
REQ-015 The control byte SHALL be [7:4] channel, [3] idle level, [2] mode (0 one-shot, 1 repeat), [1:0] cmd (00 nop, 01 load+start, 10 stop, 11 load only).
REQ-016 The byte counter SHALL advance only on i_rx_done_tick and wrap to 0 after byte PACK_NUM-1.
REQ-017 Packet execution SHALL occur in the cycle after the final-byte strobe (cycle N+1); on load, o_serial_out[ch] SHALL show pattern bit 0 in that same cycle.
REQ-018 A channel index >= CH_NUM SHALL discard the packet, leave all channels untouched, and pulse o_pkt_err at N+1.
REQ-019 Each channel SHALL have states IDLE and RUN: IDLE->RUN on load+start; RUN->IDLE on stop or on end of a one-shot pass; RUN->RUN (bit 0) on end of a repeat pass.
REQ-020 Bits SHALL be sent LSB first; bit k SHALL be held low_period cycles if freq bit k = 0, high_period cycles if 1; a period of 0 SHALL be treated as 1.
REQ-021 o_done_tick[ch] SHALL coincide with the o_bit_tick[ch] of bit DATA_BIT-1, in every pass in repeat mode.
REQ-022 In IDLE, o_serial_out[ch] SHALL equal the stored idle level, and o_bit_tick[ch], o_done_tick[ch] and o_busy[ch] SHALL be 0.
REQ-023 Load+start to a running channel SHALL restart it at bit 0 with the new data at N+1, without pulsing o_done_tick.
REQ-024 Stop SHALL force IDLE at N+1 with no o_done_tick; load-only SHALL update the stored registers without changing state, and the new data SHALL take effect at the next pass start.
REQ-025 Stop or nop to an IDLE channel SHALL have no effect apart from nop/stop updating the idle level.
REQ-026 Channels SHALL run independently and concurrently; a packet SHALL affect only its addressed channel.

Reset
REQ-027 While rst_n is asserted, the block SHALL clear the byte counter, timeout counter and all stored patterns, periods, modes and idle levels to 0, and force all channels to IDLE.
REQ-028 During reset, o_serial_out, o_bit_tick, o_done_tick, o_busy and o_pkt_err SHALL all be 0.
REQ-029 Reset asserted mid-packet or mid-pattern SHALL abort it immediately, with no tick on release.

Configuration
REQ-030 With macro PKT_TIMEOUT_EN defined, a gap of more than TIMEOUT_CLK cycles between strobes while the byte counter is non-zero SHALL reset the counter to 0 and pulse o_pkt_err once.
REQ-031 Without PKT_TIMEOUT_EN, the block SHALL have no timeout logic, and a partial packet SHALL wait indefinitely.

Verification
REQ-032 Ch0 one-shot: pattern 0x00550055, freq 0, periods 20/5, start -> 32 bits of 20 cycles each, done at cycle 640, then IDLE at level 0.
REQ-033 Ch1 repeat: freq 0xFFFF0000, periods 20/5 -> pass length 16*20 + 16*5 = 400 cycles, o_done_tick every 400 cycles, o_busy[1] held at 1.
REQ-034 Ch5 mid-run stop at bit 10 -> output goes to idle level 1 at N+1, no done tick, o_busy[5] drops.
REQ-035 Control byte channel 0xF with CH_NUM=8 -> o_pkt_err pulse, no channel changes.
REQ-036 With PKT_TIMEOUT_EN and TIMEOUT_CLK=100, send 4 bytes then idle 200 cycles, then a full packet -> one o_pkt_err pulse and the full packet executes correctly.
REQ-037 Ch0 and ch15 run concurrently with different periods, then reset is asserted mid-run -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/multi_ch_pattern_out.sv
// Packet-programmed multi-channel serial pattern generator.
// Optional build macro PKT_TIMEOUT_EN adds an inter-byte packet timeout.
module multi_ch_pattern_out #(
    parameter int DATA_BIT    = 32,
    parameter int CH_NUM      = 16,
    parameter int PERIOD_BIT  = 8,
    parameter int TIMEOUT_CLK = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_data,
    input  logic              i_rx_done_tick,
    output logic [CH_NUM-1:0] o_serial_out,
    output logic [CH_NUM-1:0] o_bit_tick,
    output logic [CH_NUM-1:0] o_done_tick,
    output logic [CH_NUM-1:0] o_busy,
    output logic              o_pkt_err
);
    localparam int NB       = DATA_BIT / 8;
    localparam int PACK_NUM = 2 * NB + 3;
    localparam int CW       = $clog2(PACK_NUM);
    localparam int BW       = $clog2(DATA_BIT);
    localparam logic [CW-1:0] LAST_BYTE = CW'(PACK_NUM - 1);

    logic [CW-1:0]         byte_cnt;
    logic [7:0]            pkt_buf [PACK_NUM-1];
    logic                  exec;
    logic                  timeout;
    logic                  ch_ok;
    logic [3:0]            cmd_ch;
    logic [1:0]            cmd;
    logic                  idle_in;
    logic                  mode_in;
    logic [DATA_BIT-1:0]   new_pat;
    logic [DATA_BIT-1:0]   new_freq;
    logic [PERIOD_BIT-1:0] new_lo;
    logic [PERIOD_BIT-1:0] new_hi;

    // The control byte is consumed straight off the bus on its strobe.
    assign exec    = i_rx_done_tick && (byte_cnt == LAST_BYTE);
    assign cmd_ch  = i_data[7:4];
    assign idle_in = i_data[3];
    assign mode_in = i_data[2];
    assign cmd     = i_data[1:0];
    assign ch_ok   = int'(cmd_ch) < CH_NUM;

    always_comb begin
        new_pat  = '0;
        new_freq = '0;
        for (int i = 0; i < NB; i++) begin
            new_pat[8*i +: 8]  = pkt_buf[i];
            new_freq[8*i +: 8] = pkt_buf[NB + i];
        end
        new_lo = PERIOD_BIT'(pkt_buf[2*NB]);
        new_hi = PERIOD_BIT'(pkt_buf[2*NB + 1]);
    end

`ifdef PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLK + 1);
    logic [TW-1:0] to_cnt;

    assign timeout = (byte_cnt != '0) && !i_rx_done_tick &&
                     (to_cnt == TW'(TIMEOUT_CLK));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            to_cnt <= '0;
        else if (i_rx_done_tick || byte_cnt == '0 || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            byte_cnt <= '0;
            for (int i = 0; i < PACK_NUM - 1; i++)
                pkt_buf[i] <= '0;
        end else if (i_rx_done_tick) begin
            if (exec) begin
                byte_cnt <= '0;
            end else begin
                pkt_buf[byte_cnt] <= i_data;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end else if (timeout) begin
            byte_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            o_pkt_err <= 1'b0;
        else
            o_pkt_err <= (exec && !ch_ok) || timeout;
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [DATA_BIT-1:0]   s_pat, s_freq, a_pat, a_freq;
        logic [PERIOD_BIT-1:0] s_lo, s_hi, a_lo, a_hi;
        logic [PERIOD_BIT-1:0] per, p_cnt;
        logic [BW-1:0]         b_idx;
        logic                  s_mode, a_mode, idle_lvl, run;
        logic                  hit, tick, last;

        assign hit  = exec && ch_ok && (cmd_ch == 4'(c));
        assign per  = a_freq[b_idx] ? a_hi : a_lo;
        // A zero period behaves as one cycle: tick on the first count.
        assign tick = run && (per == '0 || p_cnt == per - 1'b1);
        assign last = b_idx == BW'(DATA_BIT - 1);

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                s_pat <= '0; s_freq <= '0; s_lo <= '0; s_hi <= '0;
                a_pat <= '0; a_freq <= '0; a_lo <= '0; a_hi <= '0;
                s_mode <= 1'b0; a_mode <= 1'b0;
                idle_lvl <= 1'b0; run <= 1'b0;
                b_idx <= '0; p_cnt <= '0;
            end else begin
                if (run) begin
                    if (!tick) begin
                        p_cnt <= p_cnt + 1'b1;
                    end else begin
                        p_cnt <= '0;
                        if (!last) begin
                            b_idx <= b_idx + 1'b1;
                        end else begin
                            b_idx <= '0;
                            // Repeat pass start picks up any load-only data.
                            if (a_mode) begin
                                a_pat  <= s_pat;
                                a_freq <= s_freq;
                                a_lo   <= s_lo;
                                a_hi   <= s_hi;
                                a_mode <= s_mode;
                            end else begin
                                run <= 1'b0;
                            end
                        end
                    end
                end
                if (hit) begin
                    idle_lvl <= idle_in;
                    case (cmd)
                        2'b01: begin
                            s_pat <= new_pat; s_freq <= new_freq;
                            s_lo <= new_lo; s_hi <= new_hi;
                            a_pat <= new_pat; a_freq <= new_freq;
                            a_lo <= new_lo; a_hi <= new_hi;
                            s_mode <= mode_in; a_mode <= mode_in;
                            run <= 1'b1; b_idx <= '0; p_cnt <= '0;
                        end
                        2'b10: begin
                            run <= 1'b0; b_idx <= '0; p_cnt <= '0;
                        end
                        2'b11: begin
                            s_pat <= new_pat; s_freq <= new_freq;
                            s_lo <= new_lo; s_hi <= new_hi;
                            s_mode <= mode_in;
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign o_serial_out[c] = run ? a_pat[b_idx] : idle_lvl;
        assign o_bit_tick[c]   = tick;
        assign o_done_tick[c]  = tick && last;
        assign o_busy[c]       = run;
    end

endmodule

// File: tb/tb_multi_ch_pattern_out.sv
// Scoreboard bench for multi_ch_pattern_out (16- and 8-channel builds).
// Done/error pulses are matched against queued expectations by cycle.
module tb_multi_ch_pattern_out;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_data;
    logic        i_rx_done_tick;
    logic [15:0] ser16, bt16, dn16, bz16;
    logic [7:0]  ser8, bt8, dn8, bz8;
    logic        err16, err8;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct { int t; int kind; int ch; } ev_t;
    ev_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_ch_pattern_out #(
        .DATA_BIT(32), .CH_NUM(16), .PERIOD_BIT(8), .TIMEOUT_CLK(100)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .i_data(i_data),
        .i_rx_done_tick(i_rx_done_tick),
        .o_serial_out(ser16), .o_bit_tick(bt16), .o_done_tick(dn16),
        .o_busy(bz16), .o_pkt_err(err16)
    );

    multi_ch_pattern_out #(
        .DATA_BIT(32), .CH_NUM(8), .PERIOD_BIT(8), .TIMEOUT_CLK(100)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_data(i_data),
        .i_rx_done_tick(i_rx_done_tick),
        .o_serial_out(ser8), .o_bit_tick(bt8), .o_done_tick(dn8),
        .o_busy(bz8), .o_pkt_err(err8)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int t, input int k, input int ch);
        q.push_back('{t, k, ch});
    endtask

    // kind 0: done pulse on 16-ch DUT, 1: pkt_err 16-ch, 2: pkt_err 8-ch
    task automatic match_ev(input int k, input int ch);
        int idx = -1;
        total++;
        foreach (q[i])
            if (idx < 0 && q[i].kind == k && q[i].ch == ch &&
                (q[i].t < 0 || q[i].t == cyc))
                idx = i;
        if (idx >= 0) begin
            q.delete(idx);
        end else begin
            bad++;
            $display("FAIL event k%0d ch%0d: got pulse at cycle %0d, expected none",
                     k, ch, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 16; c++)
                if (dn16[c]) match_ev(0, c);
            if (err16) match_ev(1, 0);
            if (err8) match_ev(2, 0);
        end
    end

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        i_data = v;
        i_rx_done_tick = 1'b1;
        @(posedge clk); #1;
        i_rx_done_tick = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] pat, input logic [31:0] freq,
                            input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] ctl, input int at,
                            input bit split, output int e);
        logic [7:0] b [11];
        for (int i = 0; i < 4; i++) begin
            b[i]     = pat[8*i +: 8];
            b[4 + i] = freq[8*i +: 8];
        end
        b[8] = lo; b[9] = hi; b[10] = ctl;
        for (int i = 0; i < 10; i++) begin
            send_byte(b[i]);
            if (split && i == 3) begin
                repeat (200) @(posedge clk);
                #1;
            end
        end
        while (cyc < at - 2) begin
            @(posedge clk); #1;
        end
        send_byte(b[10]);
        e = cyc;
    endtask

    task automatic at_neg(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, r1, e5, s5, e3, l3, s3, n3, e0a, e15, r, e2;
        rst_n = 1'b1;
        i_data = '0;
        i_rx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(ser16), 0);
        chk("rst_busy", 32'(bz16), 0);
        chk("rst_bit_tick", 32'(bt16), 0);
        chk("rst_done", 32'(dn16), 0);
        chk("rst_pkt_err", 32'(err16), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // ch0 one-shot, 32 bits x 20 cycles
        send_pkt(32'h00550055, 32'h0, 8'd20, 8'd5, 8'h01, 0, 0, e0);
        expect_ev(e0 + 639, 0, 0);
        chk("ch0_bit0", 32'(ser16[0]), 1);
        chk("ch0_busy", 32'(bz16[0]), 1);
        // ch1 repeat, 400-cycle pass
        send_pkt(32'hA5A5A5A5, 32'hFFFF0000, 8'd20, 8'd5, 8'h15, 0, 0, e1);
        expect_ev(e1 + 399, 0, 1);
        expect_ev(e1 + 799, 0, 1);
        at_neg(e0 + 45);
        chk("ch0_bit2", 32'(ser16[0]), 1);
        at_neg(e0 + 65);
        chk("ch0_bit3", 32'(ser16[0]), 0);
        at_neg(e1 + 400);
        chk("ch1_busy_pass2", 32'(bz16[1]), 1);
        at_neg(e0 + 640);
        chk("ch0_idle_busy", 32'(bz16[0]), 0);
        chk("ch0_idle_lvl", 32'(ser16[0]), 0);
        // ch1 restarted one-shot with new data
        send_pkt(32'h1, 32'h0, 8'd2, 8'd2, 8'h11, e1 + 850, 0, r1);
        expect_ev(r1 + 63, 0, 1);
        chk("ch1_restart_bit0", 32'(ser16[1]), 1);
        chk("ch1_restart_busy", 32'(bz16[1]), 1);
        at_neg(r1 + 2);
        chk("ch1_restart_bit1", 32'(ser16[1]), 0);

        // ch5 stopped during bit 10
        send_pkt(32'h0, 32'h0, 8'd10, 8'd10, 8'h59, 0, 0, e5);
        at_neg(e5 + 50);
        chk("ch5_run_lvl", 32'(ser16[5]), 0);
        chk("ch5_run_busy", 32'(bz16[5]), 1);
        send_pkt(32'h0, 32'h0, 8'd10, 8'd10, 8'h5A, e5 + 105, 0, s5);
        chk("ch5_stop_lvl", 32'(ser16[5]), 1);
        chk("ch5_stop_busy", 32'(bz16[5]), 0);

        // ch3 repeat with load-only taking effect at next pass
        send_pkt(32'h0, 32'h0, 8'd1, 8'd1, 8'h35, 0, 0, e3);
        for (int k = 0; k < 4; k++) expect_ev(e3 + 31 + 32 * k, 0, 3);
        send_pkt(32'hFFFFFFFF, 32'h0, 8'd1, 8'd1, 8'h37, e3 + 74, 0, l3);
        chk("ch3_load_only_old", 32'(ser16[3]), 0);
        at_neg(e3 + 96);
        chk("ch3_load_only_new", 32'(ser16[3]), 1);
        send_pkt(32'h0, 32'h0, 8'd1, 8'd1, 8'h32, e3 + 133, 0, s3);
        chk("ch3_stop_busy", 32'(bz16[3]), 0);
        chk("ch3_stop_lvl", 32'(ser16[3]), 0);
        send_pkt(32'h0, 32'h0, 8'd1, 8'd1, 8'h38, 0, 0, n3);
        chk("ch3_nop_idle", 32'(ser16[3]), 1);
        chk("ch3_nop_busy", 32'(bz16[3]), 0);

        // ch0 + ch15 concurrent; ch15 is out of range for the 8-ch build
        send_pkt(32'h12345678, 32'h0000FFFF, 8'd3, 8'd7, 8'h05, 0, 0, e0a);
        send_pkt(32'hCAFEF00D, 32'h0, 8'd4, 8'd4, 8'hF5, 0, 0, e15);
        expect_ev(e15, 2, 0);
        chk("ch15_bit0", 32'(ser16[15]), 1);
        chk("ch15_busy", 32'(bz16[15]), 1);
        chk("ch8_bad_ch_busy", 32'(bz8), 32'h01);
        r = e15 + 290;
        for (int t = e0a + 159; t <= r; t += 160) expect_ev(t, 0, 0);
        for (int t = e15 + 127; t <= r; t += 128) expect_ev(t, 0, 15);
        at_neg(r);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rst_serial", 32'(ser16), 0);
        chk("mid_rst_busy", 32'(bz16), 0);
        chk("mid_rst_bit_tick", 32'(bt16), 0);
        chk("mid_rst_ser8", 32'(ser8), 0);
        chk("mid_rst_busy8", 32'(bz8), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_rst_busy", 32'(bz16), 0);
        chk("post_rst_serial", 32'(ser16), 0);

`ifdef PKT_TIMEOUT_EN
        expect_ev(-1, 1, 0);
        expect_ev(-1, 2, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        repeat (200) @(posedge clk);
        #1;
        send_pkt(32'h1, 32'h0, 8'd1, 8'd1, 8'h21, 0, 0, e2);
`else
        send_pkt(32'h1, 32'h0, 8'd1, 8'd1, 8'h21, 0, 1, e2);
`endif
        expect_ev(e2 + 31, 0, 2);
        chk("ch2_bit0", 32'(ser16[2]), 1);
        chk("ch2_busy", 32'(bz16[2]), 1);
        at_neg(e2 + 40);
        chk("ch2_done_busy", 32'(bz16[2]), 0);

        repeat (20) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d pending, expected 0 (first k%0d ch%0d t%0d)",
                     q.size(), q[0].kind, q[0].ch, q[0].t);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
